// File: rtl/bsg_front_side_bus_hop_in.sv
// Ingress stage of a front-side-bus hop: a 2-entry buffer whose head word is
// broadcast to fan_out_p consumers and retired once every consumer has taken it.
module bsg_front_side_bus_hop_in #(
  parameter int unsigned width_p   = 16,
  parameter int unsigned fan_out_p = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  input  logic [width_p-1:0]             data_i,
  output logic                           ready_o,
  output logic [fan_out_p-1:0]           v_o,
  output logic [fan_out_p*width_p-1:0]   data_o,
  input  logic [fan_out_p-1:0]           yumi_i
);

  logic [width_p-1:0]   mem_r [2];
  logic                 head_r, tail_r, empty_r, full_r;
  logic [fan_out_p-1:0] sent_r;

  logic                 head_n, tail_n, empty_n, full_n;
  logic [fan_out_p-1:0] sent_n;
  logic [fan_out_p-1:0] yumi_v;
  logic                 enq, deq;

  // Handshake decode; illegal takes are masked so they cannot corrupt sent_r.
  always_comb begin
    ready_o = ~full_r & ~reset_i;
    v_o     = {fan_out_p{~empty_r & ~reset_i}} & ~sent_r;
    yumi_v  = yumi_i & v_o;
    enq     = v_i & ready_o;
    deq     = ~empty_r & (&(sent_r | yumi_v));
  end

  // Next-state: pointer toggles, consumer bookkeeping and occupancy flags.
  always_comb begin
    head_n  = head_r;
    tail_n  = tail_r;
    empty_n = empty_r;
    full_n  = full_r;
    sent_n  = sent_r | yumi_v;

    if (deq) begin
      sent_n = '0;
      head_n = ~head_r;
    end

    if (enq) begin
      tail_n = ~tail_r;
    end

    if (enq & ~deq) begin
      empty_n = 1'b0;
      full_n  = ~empty_r;
    end else if (deq & ~enq) begin
      full_n  = 1'b0;
      empty_n = ~full_r;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_r  <= 1'b0;
      tail_r  <= 1'b0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      sent_r  <= '0;
    end else begin
      head_r  <= head_n;
      tail_r  <= tail_n;
      empty_r <= empty_n;
      full_r  <= full_n;
      sent_r  <= sent_n;
    end
  end

  // Storage is intentionally left unreset; validity is tracked by empty_r/full_r.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_r[tail_r] <= data_i;
    end
  end

  assign data_o = {fan_out_p{mem_r[head_r]}};

  // A consumer must only take a word it is currently being offered.
  yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
                               ((yumi_i & ~v_o) == '0));

endmodule
